// File: rtl/fp_mul_setup_stage.sv
// fp_mul_setup_stage: unpacks two floating-point operands, restores hidden
// bits, forms the biased product exponent and classifies special operands.
// A two-entry skid buffer (output reg + skid reg) decouples the upstream
// ready from downstream stalls so ready_o is a pure register output.

// Per-operand unpack and classification; instantiated once per operand.
module fp_mul_setup_unpack #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic [EXP_W+MAN_W:0] op,
  output logic                 sgn,
  output logic [EXP_W-1:0]     exp,
  output logic [MAN_W:0]       sig,
  output logic                 is_zero,
  output logic                 is_inf,
  output logic                 is_nan
);
  logic [MAN_W-1:0] man;

  assign sgn = op[EXP_W+MAN_W];
  assign exp = op[EXP_W+MAN_W-1:MAN_W];
  assign man = op[MAN_W-1:0];

  // Denormals are flushed to zero, so a zero exponent alone marks zero.
  always_comb begin
    is_zero = (exp == '0);
    is_inf  = (&exp) && (man == '0);
    is_nan  = (&exp) && (man != '0);
    sig     = {1'b1, man};
  end
endmodule

module fp_mul_setup_stage #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23,
  parameter int BIAS  = 2**(EXP_W-1)-1
) (
  input  logic                        clk,
  input  logic                        n_rst,
  input  logic                        flush,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [EXP_W+MAN_W:0]        a,
  input  logic [EXP_W+MAN_W:0]        b,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [MAN_W:0]              sig_a,
  output logic [MAN_W:0]              sig_b,
  output logic signed [EXP_W+1:0]     exp_sum,
  output logic                        sign,
  output logic                        is_zero,
  output logic                        is_inf,
  output logic                        is_nan
);
  localparam int OP_W  = EXP_W + MAN_W + 1;
  localparam int SIG_W = MAN_W + 1;
  localparam int ES_W  = EXP_W + 2;
  localparam logic signed [ES_W-1:0] BIAS_S = ES_W'(BIAS);

  typedef struct packed {
    logic [SIG_W-1:0]       sig_a;
    logic [SIG_W-1:0]       sig_b;
    logic signed [ES_W-1:0] exp_sum;
    logic                   sign;
    logic                   is_zero;
    logic                   is_inf;
    logic                   is_nan;
  } res_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // ---------------------------------------------------------------------
  // Operand unpack: lane 0 = a, lane 1 = b
  // ---------------------------------------------------------------------
  logic [1:0][OP_W-1:0]  ops;
  logic [1:0]            op_sgn, op_zero, op_inf, op_nan;
  logic [1:0][EXP_W-1:0] op_exp;
  logic [1:0][SIG_W-1:0] op_sig;

  assign ops[0] = a;
  assign ops[1] = b;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      fp_mul_setup_unpack #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_unpack (
        .op      (ops[gi]),
        .sgn     (op_sgn[gi]),
        .exp     (op_exp[gi]),
        .sig     (op_sig[gi]),
        .is_zero (op_zero[gi]),
        .is_inf  (op_inf[gi]),
        .is_nan  (op_nan[gi])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Result formation with special-case priority NaN > Inf > Zero
  // ---------------------------------------------------------------------
  res_t res_new;
  logic sp_nan, sp_inf, sp_zero;

  // Classify the pair and zero the numeric fields whenever a flag is set.
  always_comb begin
    sp_nan  = (|op_nan) || (op_inf[0] && op_zero[1]) || (op_zero[0] && op_inf[1]);
    sp_inf  = !sp_nan && (|op_inf);
    sp_zero = !sp_nan && !sp_inf && (|op_zero);

    res_new         = '0;
    res_new.sign    = op_sgn[0] ^ op_sgn[1];
    res_new.is_nan  = sp_nan;
    res_new.is_inf  = sp_inf;
    res_new.is_zero = sp_zero;
    if (!(sp_nan || sp_inf || sp_zero)) begin
      res_new.sig_a   = op_sig[0];
      res_new.sig_b   = op_sig[1];
      // Zero-extended exponents keep the sum non-negative before the bias.
      res_new.exp_sum = $signed({2'b00, op_exp[0]}) + $signed({2'b00, op_exp[1]}) - BIAS_S;
    end
  end

  // ---------------------------------------------------------------------
  // Skid buffer control
  // ---------------------------------------------------------------------
  buf_state_t state_q, state_d;
  res_t       out_q, skid_q;
  logic       accept, drain;
  logic       load_out_new, load_out_skid, load_skid;

  assign valid_o = (state_q != EMPTY);
  assign ready_o = (state_q != FULL);
  assign accept  = valid_i && ready_o;
  assign drain   = valid_o && ready_i;

  // Buffer state register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next-state and data-steering decode; flush wins over accept and drain.
  always_comb begin
    state_d       = state_q;
    load_out_new  = 1'b0;
    load_out_skid = 1'b0;
    load_skid     = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            state_d      = ONE;
            load_out_new = 1'b1;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_out_new = 1'b1;
          end else if (accept) begin
            state_d   = FULL;
            load_skid = 1'b1;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (drain) begin
            state_d       = ONE;
            load_out_skid = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Output and skid data registers; cleared on reset so outputs read zero.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out_new)       out_q <= res_new;
      else if (load_out_skid) out_q <= skid_q;
      if (load_skid)          skid_q <= res_new;
    end
  end

  assign sig_a   = out_q.sig_a;
  assign sig_b   = out_q.sig_b;
  assign exp_sum = out_q.exp_sum;
  assign sign    = out_q.sign;
  assign is_zero = out_q.is_zero;
  assign is_inf  = out_q.is_inf;
  assign is_nan  = out_q.is_nan;
endmodule
